// File: rtl/div_cfg_ctrl.sv
// Run/stop and ratio controller for an even-ratio clock divider: div_out = clk / (2*cur_half).
// Optional macro DIV_CFG_CTRL_SYNC_EN adds a two-flop synchronizer on en.
module div_cfg_ctrl #(
    parameter int          CNT_W    = 8,
    parameter int unsigned DEF_HALF = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             div_out,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] cur_half,
    output logic             err_zero
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] cur_half_q, cur_half_d;
    logic [CNT_W-1:0] pend_half_q, pend_half_d;
    logic             pend_q, pend_d;
    logic             div_q, div_d;
    logic             edge_q, edge_d;
    logic             err_q, err_d;
    logic             en_s;
    logic             tc;
    logic             apply;

`ifdef DIV_CFG_CTRL_SYNC_EN
    logic en_meta_q, en_sync_q;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            en_meta_q <= 1'b0;
            en_sync_q <= 1'b0;
        end else begin
            en_meta_q <= en;
            en_sync_q <= en_meta_q;
        end
    end

    assign en_s = en_sync_q;
`else
    assign en_s = en;
`endif

    assign tc = (count_q == (cur_half_q - CNT_W'(1)));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        div_d       = div_q;
        edge_d      = 1'b0;
        err_d       = 1'b0;
        cur_half_d  = cur_half_q;
        pend_d      = pend_q;
        pend_half_d = pend_half_q;
        apply       = 1'b0;

        case (state_q)
            IDLE: begin
                count_d = '0;
                div_d   = 1'b0;
                if (en_s) begin
                    state_d = RUN;
                end
            end
            RUN, STOP: begin
                count_d = tc ? '0 : count_q + CNT_W'(1);
                // Re-asserting en while stopping resumes without a phase reset.
                if (state_q == RUN || en_s) begin
                    state_d = en_s ? RUN : STOP;
                    if (tc) begin
                        div_d  = ~div_q;
                        edge_d = 1'b1;
                        apply  = div_q;
                    end
                end else if (tc) begin
                    div_d   = 1'b0;
                    edge_d  = div_q;
                    apply   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                div_d   = 1'b0;
            end
        endcase

        if (apply && pend_q) begin
            cur_half_d = pend_half_q;
            pend_d     = 1'b0;
        end

        // Accept only happens with pend_q low, so it never collides with an apply.
        if (cfg_valid && !pend_q) begin
            if (cfg_half == '0) begin
                err_d = 1'b1;
            end else if (state_q == IDLE) begin
                cur_half_d = cfg_half;
            end else begin
                pend_half_d = cfg_half;
                pend_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= IDLE;
            count_q     <= '0;
            div_q       <= 1'b0;
            edge_q      <= 1'b0;
            err_q       <= 1'b0;
            cur_half_q  <= CNT_W'(DEF_HALF);
            pend_q      <= 1'b0;
            pend_half_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            div_q       <= div_d;
            edge_q      <= edge_d;
            err_q       <= err_d;
            cur_half_q  <= cur_half_d;
            pend_q      <= pend_d;
            pend_half_q <= pend_half_d;
        end
    end

    assign cfg_ready  = ~pend_q;
    assign div_out    = div_q;
    assign edge_pulse = edge_q;
    assign cur_half   = cur_half_q;
    assign err_zero   = err_q;

endmodule

// File: tb/tb_div_cfg_ctrl.sv
// Directed self-checking bench for div_cfg_ctrl (default build, en sampled directly).
module tb_div_cfg_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             res = 1'b0;
    logic             en = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_half = '0;
    logic             cfg_ready;
    logic             div_out;
    logic             edge_pulse;
    logic [CNT_W-1:0] cur_half;
    logic             err_zero;

    int checks = 0;
    int errors = 0;

    div_cfg_ctrl #(.CNT_W(CNT_W), .DEF_HALF(4)) dut (
        .clk        (clk),
        .res        (res),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_half   (cfg_half),
        .cfg_ready  (cfg_ready),
        .div_out    (div_out),
        .edge_pulse (edge_pulse),
        .cur_half   (cur_half),
        .err_zero   (err_zero)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drop en and give any stop sequence ample time to return to IDLE.
    task automatic go_idle(input string tag);
        en = 1'b0;
        repeat (12) tick();
        checks++;
        if (div_out !== 1'b0 || edge_pulse !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle div_out=%b edge_pulse=%b required 0 0", tag, div_out, edge_pulse);
        end
    endtask

    task automatic set_half_idle(input logic [CNT_W-1:0] h);
        cfg_valid = 1'b1;
        cfg_half  = h;
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (cur_half !== h || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_cfg cur_half=%0d cfg_ready=%b required %0d 1", cur_half, cfg_ready, h);
        end
    endtask

    task automatic test_reset;
        res = 1'b1;
        #3;
        checks++;
        if (div_out !== 1'b0 || edge_pulse !== 1'b0 || cfg_ready !== 1'b1 ||
            cur_half !== 8'd4 || err_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals div=%b edge=%b rdy=%b half=%0d err=%b required 0 0 1 4 0",
                     div_out, edge_pulse, cfg_ready, cur_half, err_zero);
        end
        tick();
        tick();
        res = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (div_out !== 1'b0 || edge_pulse !== 1'b0 || cfg_ready !== 1'b1 || cur_half !== 8'd4) begin
                errors++;
                $display("FAIL reset_idle cycle %0d div=%b edge=%b rdy=%b half=%0d required 0 0 1 4",
                         k, div_out, edge_pulse, cfg_ready, cur_half);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_default_run;
        logic exp_div, exp_edge;
        en = 1'b1;
        tick();
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_div  = ((k / 4) % 2) == 1;
            exp_edge = (k % 4) == 0;
            checks++;
            if (div_out !== exp_div || edge_pulse !== exp_edge) begin
                errors++;
                $display("FAIL default_run edge %0d div=%b edge=%b required %b %b",
                         k, div_out, edge_pulse, exp_div, exp_edge);
            end
        end
        go_idle("default_run");
        $display("test_default_run done");
    endtask

    task automatic test_reconfig;
        logic exp_div;
        en = 1'b1;
        tick();
        repeat (5) tick();
        cfg_valid = 1'b1;
        cfg_half  = 8'd2;
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0 || cur_half !== 8'd4 || div_out !== 1'b1) begin
            errors++;
            $display("FAIL reconfig_accept rdy=%b half=%0d div=%b required 0 4 1", cfg_ready, cur_half, div_out);
        end
        tick();
        checks++;
        if (cfg_ready !== 1'b0 || cur_half !== 8'd4 || div_out !== 1'b1) begin
            errors++;
            $display("FAIL reconfig_hold rdy=%b half=%0d div=%b required 0 4 1", cfg_ready, cur_half, div_out);
        end
        tick();
        checks++;
        if (div_out !== 1'b0 || edge_pulse !== 1'b1 || cur_half !== 8'd2 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reconfig_apply div=%b edge=%b half=%0d rdy=%b required 0 1 2 1",
                     div_out, edge_pulse, cur_half, cfg_ready);
        end
        for (int k = 9; k <= 14; k++) begin
            tick();
            exp_div = ((k - 8) / 2) % 2 == 1;
            checks++;
            if (div_out !== exp_div || edge_pulse !== (k % 2 == 0)) begin
                errors++;
                $display("FAIL reconfig_period edge %0d div=%b edge=%b required %b %b",
                         k, div_out, edge_pulse, exp_div, (k % 2 == 0));
            end
        end
        go_idle("reconfig");
        set_half_idle(8'd4);
        $display("test_reconfig done");
    endtask

    task automatic test_stop_high;
        en = 1'b1;
        tick();
        repeat (5) tick();
        en = 1'b0;
        for (int k = 6; k <= 8; k++) begin
            tick();
            checks++;
            if (div_out !== (k != 8) || edge_pulse !== (k == 8)) begin
                errors++;
                $display("FAIL stop_high edge %0d div=%b edge=%b required %b %b",
                         k, div_out, edge_pulse, (k != 8), (k == 8));
            end
        end
        for (int k = 9; k <= 16; k++) begin
            tick();
            checks++;
            if (div_out !== 1'b0 || edge_pulse !== 1'b0) begin
                errors++;
                $display("FAIL stop_quiet edge %0d div=%b edge=%b required 0 0", k, div_out, edge_pulse);
            end
        end
        en = 1'b1;
        tick();
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (div_out !== (k == 4) || edge_pulse !== (k == 4)) begin
                errors++;
                $display("FAIL restart edge %0d div=%b edge=%b required %b %b",
                         k, div_out, edge_pulse, (k == 4), (k == 4));
            end
        end
        go_idle("stop_high");
        $display("test_stop_high done");
    endtask

    task automatic test_zero_cfg;
        en = 1'b1;
        tick();
        tick();
        cfg_valid = 1'b1;
        cfg_half  = 8'd0;
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (err_zero !== 1'b1 || cfg_ready !== 1'b1 || cur_half !== 8'd4) begin
            errors++;
            $display("FAIL zero_cfg err=%b rdy=%b half=%0d required 1 1 4", err_zero, cfg_ready, cur_half);
        end
        tick();
        checks++;
        if (err_zero !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse_len err=%b required 0", err_zero);
        end
        for (int k = 4; k <= 8; k++) begin
            tick();
            checks++;
            if (div_out !== (k != 8) || cur_half !== 8'd4) begin
                errors++;
                $display("FAIL zero_period edge %0d div=%b half=%0d required %b 4",
                         k, div_out, cur_half, (k != 8));
            end
        end
        go_idle("zero_cfg");
        $display("test_zero_cfg done");
    endtask

    // H=1 run, plus an accept landing on an applying TC (must stay pending one more period).
    task automatic test_half_one;
        set_half_idle(8'd1);
        en = 1'b1;
        tick();
        tick();
        checks++;
        if (div_out !== 1'b1 || edge_pulse !== 1'b1) begin
            errors++;
            $display("FAIL half1_rise div=%b edge=%b required 1 1", div_out, edge_pulse);
        end
        cfg_valid = 1'b1;
        cfg_half  = 8'd3;
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (div_out !== 1'b0 || cur_half !== 8'd1 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL coincident_accept div=%b half=%0d rdy=%b required 0 1 0", div_out, cur_half, cfg_ready);
        end
        tick();
        checks++;
        if (div_out !== 1'b1 || cur_half !== 8'd1) begin
            errors++;
            $display("FAIL half1_second_rise div=%b half=%0d required 1 1", div_out, cur_half);
        end
        tick();
        checks++;
        if (div_out !== 1'b0 || cur_half !== 8'd3 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL half1_apply div=%b half=%0d rdy=%b required 0 3 1", div_out, cur_half, cfg_ready);
        end
        for (int k = 5; k <= 7; k++) begin
            tick();
            checks++;
            if (div_out !== (k == 7)) begin
                errors++;
                $display("FAIL half3_period edge %0d div=%b required %b", k, div_out, (k == 7));
            end
        end
        go_idle("half_one");
        set_half_idle(8'd4);
        $display("test_half_one done");
    endtask

    task automatic test_async_reset;
        en = 1'b1;
        tick();
        repeat (4) tick();
        cfg_valid = 1'b1;
        cfg_half  = 8'd2;
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (div_out !== 1'b1 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL areset_setup div=%b rdy=%b required 1 0", div_out, cfg_ready);
        end
        #2;
        res = 1'b1;
        #1;
        checks++;
        if (div_out !== 1'b0 || cur_half !== 8'd4 || cfg_ready !== 1'b1 || edge_pulse !== 1'b0) begin
            errors++;
            $display("FAIL areset_now div=%b half=%0d rdy=%b edge=%b required 0 4 1 0",
                     div_out, cur_half, cfg_ready, edge_pulse);
        end
        en = 1'b0;
        tick();
        res = 1'b0;
        repeat (10) tick();
        checks++;
        if (cur_half !== 8'd4 || cfg_ready !== 1'b1 || div_out !== 1'b0) begin
            errors++;
            $display("FAIL areset_after half=%0d rdy=%b div=%b required 4 1 0", cur_half, cfg_ready, div_out);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_reconfig();
        test_stop_high();
        test_zero_cfg();
        test_half_one();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
